// File: rtl/bias3_delta_gen.sv
// ---------------------------------------------------------------------------
// bias3_delta_gen
//
// Accumulates BATCH output-layer error gradient samples (four Q8.8 lanes),
// scales each lane sum by the learning rate 2^-LR_SHIFT, negates it and
// saturates it to a 16-bit Q8.8 bias increment. The increments are held
// until the bias-update phase (ctrl == 4'b0011). They are presented for
// exactly one cycle, and then the block returns to accumulating.
//
// Parameters
//   BATCH     gradient samples per bias update (1..16)
//   LR_SHIFT  learning rate exponent, rate = 2^-LR_SHIFT (0..15)
//
// Ports
//   clk                       rising-edge clock
//   rst                       asynchronous active-high reset
//   ctrl[3:0]                 phase code, 4'b0011 = bias-update phase
//   grad_valid                a gradient sample is present
//   grad_1..grad_4            signed Q8.8 gradients
//   grad_ready                block accepts a sample (ACCUM state)
//   deltab3_1..deltab3_4      signed Q8.8 bias increments, nonzero only
//                             during the update cycle
//   delta_ready               scaled deltas pending (HOLD state)
// ---------------------------------------------------------------------------
module bias3_delta_gen #(
  parameter int BATCH    = 4,
  parameter int LR_SHIFT = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         ctrl,
  input  logic               grad_valid,
  input  logic signed [15:0] grad_1,
  input  logic signed [15:0] grad_2,
  input  logic signed [15:0] grad_3,
  input  logic signed [15:0] grad_4,
  output logic               grad_ready,
  output logic signed [15:0] deltab3_1,
  output logic signed [15:0] deltab3_2,
  output logic signed [15:0] deltab3_3,
  output logic signed [15:0] deltab3_4,
  output logic               delta_ready
);

  localparam logic [3:0] UPDATE_PHASE = 4'b0011;
  localparam logic [4:0] LAST_CNT     = 5'(BATCH - 1);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCALE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [4:0]               r_cnt;
  logic signed [23:0]       r_sum   [4];
  logic signed [15:0]       r_delta [4];
  logic signed [15:0]       w_grad  [4];
  logic                     w_accept;
  logic                     w_update;

  // Clamp a 24-bit signed value into the 16-bit signed range.
  function automatic logic signed [15:0] sat16(input logic signed [23:0] x);
    if (x > 24'sd32767)
      return 16'sh7FFF;
    else if (x < -24'sd32768)
      return 16'sh8000;
    else
      return x[15:0];
  endfunction

  // Gradient descent step: the bias moves against the gradient. The
  // arithmetic shift floors toward minus infinity before negation. The sum
  // magnitude stays well under 2^23, so the 24-bit negation cannot wrap.
  function automatic logic signed [15:0] scale_neg(input logic signed [23:0] sum);
    logic signed [23:0] shifted;
    shifted = sum >>> LR_SHIFT;
    return sat16(-shifted);
  endfunction

  assign w_grad[0] = grad_1;
  assign w_grad[1] = grad_2;
  assign w_grad[2] = grad_3;
  assign w_grad[3] = grad_4;

  assign w_accept = grad_valid && (r_state == ACCUM);
  assign w_update = (r_state == HOLD) && (ctrl == UPDATE_PHASE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ACCUM:   if (w_accept && (r_cnt == LAST_CNT)) w_next = SCALE;
      SCALE:   w_next = HOLD;
      HOLD:    if (w_update) w_next = ACCUM;
      default: w_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ACCUM;
      r_cnt   <= 5'd0;
      for (int i = 0; i < 4; i++) begin
        r_sum[i]   <= 24'sd0;
        r_delta[i] <= 16'sd0;
      end
    end else begin
      r_state <= w_next;
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            r_cnt <= r_cnt + 5'd1;
            for (int i = 0; i < 4; i++)
              r_sum[i] <= r_sum[i] + {{8{w_grad[i][15]}}, w_grad[i]};
          end
        end
        SCALE: begin
          for (int i = 0; i < 4; i++)
            r_delta[i] <= scale_neg(r_sum[i]);
        end
        HOLD: begin
          // Clearing on the update edge guarantees each delta is emitted once.
          if (w_update) begin
            r_cnt <= 5'd0;
            for (int i = 0; i < 4; i++) begin
              r_sum[i]   <= 24'sd0;
              r_delta[i] <= 16'sd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign grad_ready  = (r_state == ACCUM);
  assign delta_ready = (r_state == HOLD);

  assign deltab3_1 = w_update ? r_delta[0] : 16'sd0;
  assign deltab3_2 = w_update ? r_delta[1] : 16'sd0;
  assign deltab3_3 = w_update ? r_delta[2] : 16'sd0;
  assign deltab3_4 = w_update ? r_delta[3] : 16'sd0;

endmodule

// File: tb/tb_bias3_delta_gen.sv
// ---------------------------------------------------------------------------
// tb_bias3_delta_gen
//
// Three instances share clock, reset and gradient lanes:
//   u_main  BATCH=4, LR_SHIFT=6
//   u_sat   BATCH=4, LR_SHIFT=0  (saturation behaviour)
//   u_b1    BATCH=1, LR_SHIFT=2  (own valid/ctrl, idle during other tests)
// ---------------------------------------------------------------------------
module tb_bias3_delta_gen;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [3:0]         ctrl = 4'b0000;
  logic               valid = 1'b0;
  logic [3:0]         c1 = 4'b0000;
  logic               v1 = 1'b0;
  logic signed [15:0] g [4];

  logic               m_gr, m_dr, s_gr, s_dr, b_gr, b_dr;
  logic signed [15:0] m_d [4];
  logic signed [15:0] s_d [4];
  logic signed [15:0] b_d [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bias3_delta_gen #(.BATCH(4), .LR_SHIFT(6)) u_main (
    .clk(clk), .rst(rst), .ctrl(ctrl), .grad_valid(valid),
    .grad_1(g[0]), .grad_2(g[1]), .grad_3(g[2]), .grad_4(g[3]),
    .grad_ready(m_gr),
    .deltab3_1(m_d[0]), .deltab3_2(m_d[1]), .deltab3_3(m_d[2]), .deltab3_4(m_d[3]),
    .delta_ready(m_dr));

  bias3_delta_gen #(.BATCH(4), .LR_SHIFT(0)) u_sat (
    .clk(clk), .rst(rst), .ctrl(ctrl), .grad_valid(valid),
    .grad_1(g[0]), .grad_2(g[1]), .grad_3(g[2]), .grad_4(g[3]),
    .grad_ready(s_gr),
    .deltab3_1(s_d[0]), .deltab3_2(s_d[1]), .deltab3_3(s_d[2]), .deltab3_4(s_d[3]),
    .delta_ready(s_dr));

  bias3_delta_gen #(.BATCH(1), .LR_SHIFT(2)) u_b1 (
    .clk(clk), .rst(rst), .ctrl(c1), .grad_valid(v1),
    .grad_1(g[0]), .grad_2(g[1]), .grad_3(g[2]), .grad_4(g[3]),
    .grad_ready(b_gr),
    .deltab3_1(b_d[0]), .deltab3_2(b_d[1]), .deltab3_3(b_d[2]), .deltab3_4(b_d[3]),
    .delta_ready(b_dr));

  // One batch: each lane receives the same sample four times.
  typedef struct packed {
    logic [3:0][15:0] g;   // lane sample values
    logic [3:0][15:0] e6;  // expected deltas, LR_SHIFT=6
    logic [3:0][15:0] e0;  // expected deltas, LR_SHIFT=0
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_g(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    g[0] = a; g[1] = b; g[2] = c; g[3] = d;
  endtask

  task automatic feed_same(input logic [15:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      valid = 1'b1;
      set_g(v, v, v, v);
      step();
    end
    valid = 1'b0;
  endtask

  task automatic run_batch(input int i);
    // ctrl held at the update code while accumulating: must have no effect
    ctrl = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      valid = 1'b1;
      set_g(vecs[i].g[0], vecs[i].g[1], vecs[i].g[2], vecs[i].g[3]);
      #1;
      chk($sformatf("v%0d accum grad_ready", i), 16'(m_gr), 16'd1);
      chk($sformatf("v%0d accum deltab3_1", i), m_d[0], 16'h0000);
      #0 step();
    end
    // SCALE cycle: extra valid samples are ignored
    set_g(16'h1234, 16'h1234, 16'h1234, 16'h1234);
    #1;
    chk($sformatf("v%0d scale grad_ready", i), 16'(m_gr), 16'd0);
    chk($sformatf("v%0d scale delta_ready", i), 16'(m_dr), 16'd0);
    chk($sformatf("v%0d scale deltab3_4", i), m_d[3], 16'h0000);
    step();
    // HOLD, not yet the update phase
    valid = 1'b0;
    ctrl  = 4'b0000;
    #1;
    chk($sformatf("v%0d hold delta_ready", i), 16'(m_dr), 16'd1);
    chk($sformatf("v%0d hold grad_ready", i), 16'(m_gr), 16'd0);
    chk($sformatf("v%0d hold deltab3_1 idle", i), m_d[0], 16'h0000);
    ctrl = 4'b0011;
    #1;
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("v%0d lr6 deltab3_%0d", i, l + 1), m_d[l], vecs[i].e6[l]);
      chk($sformatf("v%0d lr0 deltab3_%0d", i, l + 1), s_d[l], vecs[i].e0[l]);
    end
    step();
    ctrl = 4'b0000;
    #1;
    chk($sformatf("v%0d after grad_ready", i), 16'(m_gr), 16'd1);
    chk($sformatf("v%0d after delta_ready", i), 16'(m_dr), 16'd0);
    chk($sformatf("v%0d after deltab3_2", i), m_d[1], 16'h0000);
  endtask

  initial begin
    // lane order in the packed fields: [0] = lane 1
    vecs[0].g  = {16'h0100, 16'h0100, 16'h0100, 16'h0100};
    vecs[0].e6 = {16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFFF0};
    vecs[0].e0 = {16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00};
    vecs[1].g  = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[1].e6 = {16'h0001, 16'h0001, 16'h0001, 16'h0001};
    vecs[1].e0 = {16'h0004, 16'h0004, 16'h0004, 16'h0004};
    vecs[2].g  = {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    vecs[2].e6 = {16'hF801, 16'hF801, 16'hF801, 16'hF801};
    vecs[2].e0 = {16'h8000, 16'h8000, 16'h8000, 16'h8000};
    vecs[3].g  = {16'h8000, 16'h8000, 16'h8000, 16'h8000};
    vecs[3].e6 = {16'h0800, 16'h0800, 16'h0800, 16'h0800};
    vecs[3].e0 = {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    // lane1=0x0100, lane2=0xFFFF, lane3=0x0000, lane4=0x0010
    vecs[4].g  = {16'h0010, 16'h0000, 16'hFFFF, 16'h0100};
    vecs[4].e6 = {16'hFFFF, 16'h0000, 16'h0001, 16'hFFF0};
    vecs[4].e0 = {16'hFFC0, 16'h0000, 16'h0004, 16'hFC00};

    set_g(16'h0, 16'h0, 16'h0, 16'h0);

    // Reset state
    #2;
    chk("reset grad_ready", 16'(m_gr), 16'd1);
    chk("reset delta_ready", 16'(m_dr), 16'd0);
    chk("reset deltab3_1", m_d[0], 16'h0000);
    chk("reset b1 grad_ready", 16'(b_gr), 16'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven batches
    for (int i = 0; i < 5; i++) run_batch(i);

    // Hold for 10 cycles, then update phase held for 3 cycles
    feed_same(16'h0100, 4);
    step();
    ctrl = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("hold%0d delta_ready", k), 16'(m_dr), 16'd1);
      chk($sformatf("hold%0d deltab3_1", k), m_d[0], 16'h0000);
      step();
    end
    ctrl = 4'b0011;
    #1;
    chk("upd1 deltab3_1", m_d[0], 16'hFFF0);
    chk("upd1 deltab3_4", m_d[3], 16'hFFF0);
    step();
    chk("upd2 grad_ready", 16'(m_gr), 16'd1);
    chk("upd2 deltab3_1", m_d[0], 16'h0000);
    step();
    chk("upd3 grad_ready", 16'(m_gr), 16'd1);
    chk("upd3 deltab3_1", m_d[0], 16'h0000);
    chk("upd3 delta_ready", 16'(m_dr), 16'd0);
    ctrl = 4'b0000;

    // Back-pressure: valid held high, sample value = cycle*100.
    // Batch 1 takes 100..400 (sum 1000), 500/600 are refused,
    // batch 2 takes 700..1000 (sum 3400).
    for (int cyc = 1; cyc <= 12; cyc++) begin
      valid = 1'b1;
      set_g(16'(cyc * 100), 16'(cyc * 100), 16'(cyc * 100), 16'(cyc * 100));
      ctrl = (cyc == 6 || cyc == 12) ? 4'b0011 : 4'b0000;
      #1;
      if (cyc == 5 || cyc == 11)
        chk($sformatf("bp c%0d grad_ready", cyc), 16'(m_gr), 16'd0);
      if (cyc == 6) begin
        chk("bp b1 lr6", m_d[0], 16'hFFF1);
        chk("bp b1 lr0", s_d[2], 16'hFC18);
      end
      if (cyc == 12) begin
        chk("bp b2 lr6", m_d[1], 16'hFFCB);
        chk("bp b2 lr0", s_d[3], 16'hF2B8);
      end
      step();
    end
    valid = 1'b0;
    ctrl  = 4'b0000;

    // Reset mid-ACCUM after two samples
    feed_same(16'h7FFF, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("rst accum grad_ready", 16'(m_gr), 16'd1);
    chk("rst accum delta_ready", 16'(m_dr), 16'd0);
    step();
    rst = 1'b0;
    feed_same(16'h0100, 4);
    step();
    ctrl = 4'b0011;
    #1;
    chk("post-rst lr6", m_d[0], 16'hFFF0);
    chk("post-rst lr0", s_d[1], 16'hFC00);
    step();
    ctrl = 4'b0000;

    // Reset in HOLD while the update phase is presented
    feed_same(16'h0100, 4);
    step();
    ctrl = 4'b0011;
    #1;
    chk("hold-rst before", m_d[0], 16'hFFF0);
    rst = 1'b1;
    #1;
    chk("hold-rst deltab3_1", m_d[0], 16'h0000);
    chk("hold-rst delta_ready", 16'(m_dr), 16'd0);
    chk("hold-rst grad_ready", 16'(m_gr), 16'd1);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hold-rst after%0d deltab3_1", k), m_d[0], 16'h0000);
      chk($sformatf("hold-rst after%0d delta_ready", k), 16'(m_dr), 16'd0);
      step();
    end
    ctrl = 4'b0000;

    // BATCH=1 instance: every accepted sample goes straight to SCALE
    v1 = 1'b1;
    set_g(16'h0100, 16'h0100, 16'hFFFF, 16'h0000);
    step();
    v1 = 1'b0;
    #1;
    chk("b1 scale grad_ready", 16'(b_gr), 16'd0);
    chk("b1 main untouched", 16'(m_gr), 16'd1);
    step();
    chk("b1 hold delta_ready", 16'(b_dr), 16'd1);
    c1 = 4'b0011;
    #1;
    chk("b1 deltab3_1", b_d[0], 16'hFFC0);
    chk("b1 deltab3_3", b_d[2], 16'h0001);
    chk("b1 deltab3_4", b_d[3], 16'h0000);
    step();
    c1 = 4'b0000;
    #1;
    chk("b1 back grad_ready", 16'(b_gr), 16'd1);
    chk("b1 back deltab3_1", b_d[0], 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety bound on total simulation time
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
